// File: rtl/cam_cfg_pkg.sv
// Shared constants, state encoding and delay sizing for the OV7670 configuration sequencer.
package cam_cfg_pkg;

  localparam logic [15:0] CFG_END   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY = 16'hFFF0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_DELAY   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  function automatic int delay_cycles(input int clk_freq_hz, input int delay_ms);
    return (clk_freq_hz / 1000) * delay_ms;
  endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter that parks at zero; o_zero flags the end of a delay entry.
module cfg_delay_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/cam_cfg_ctrl.sv
// Walks the camera configuration ROM from address 0, issuing one SCCB write per entry,
// honouring delay and end-of-table markers, and flagging completion on o_done.
module cam_cfg_ctrl
  import cam_cfg_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int DELAY_MS    = 1,
  parameter int ROM_AW      = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_sccb_start,
  output logic [7:0]        o_sccb_addr,
  output logic [7:0]        o_sccb_data,
  input  logic              i_sccb_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int                DLY       = delay_cycles(CLK_FREQ_HZ, DELAY_MS);
  localparam int                TW        = $clog2(DLY + 1);
  localparam logic [TW-1:0]     TMR_LOAD  = TW'(DLY - 1);
  localparam logic [ROM_AW-1:0] LAST_ADDR = '1;

  state_t            r_state, w_state_next;
  logic [ROM_AW-1:0] r_rom_addr, w_rom_addr_next;
  logic              r_sccb_start, w_sccb_start_next;
  logic [7:0]        r_sccb_addr, w_sccb_addr_next;
  logic [7:0]        r_sccb_data, w_sccb_data_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic              r_wait_first, w_wait_first_next;
  logic              w_advance;
  logic              w_tmr_load;
  logic              w_tmr_zero;

  cfg_delay_timer #(.W(TW)) u_delay_timer (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_load  (w_tmr_load),
    .i_value (TMR_LOAD),
    .o_zero  (w_tmr_zero)
  );

  always_comb begin
    w_state_next      = r_state;
    w_rom_addr_next   = r_rom_addr;
    w_sccb_start_next = 1'b0;
    w_sccb_addr_next  = r_sccb_addr;
    w_sccb_data_next  = r_sccb_data;
    w_wait_first_next = 1'b0;
    w_advance         = 1'b0;
    w_tmr_load        = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_next    = ST_FETCH;
          w_rom_addr_next = '0;
        end
      end
      ST_FETCH:  w_state_next = ST_DECODE;
      ST_DECODE: begin
        if (i_rom_data == CFG_END) begin
          w_state_next = ST_DONE;
        end else if (i_rom_data == CFG_DELAY) begin
          w_state_next = ST_DELAY;
          w_tmr_load   = 1'b1;
        end else begin
          w_sccb_addr_next = i_rom_data[15:8];
          w_sccb_data_next = i_rom_data[7:0];
          w_state_next     = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (i_sccb_ready) begin
          w_sccb_start_next = 1'b1;
          w_wait_first_next = 1'b1;
          w_state_next      = ST_WR_WAIT;
        end
      end
      // The master only drops ready after it has seen the start, so the first cycle is blind.
      ST_WR_WAIT: w_advance = !r_wait_first && i_sccb_ready;
      ST_DELAY:   w_advance = w_tmr_zero;
      default:    w_state_next = ST_IDLE;
    endcase

    if (w_advance) begin
      if (r_rom_addr == LAST_ADDR) begin
        w_state_next = ST_DONE;
      end else begin
        w_rom_addr_next = r_rom_addr + 1'b1;
        w_state_next    = ST_FETCH;
      end
    end

    w_busy_next = (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
    w_done_next = (w_state_next == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state      <= ST_IDLE;
      r_rom_addr   <= '0;
      r_sccb_start <= 1'b0;
      r_sccb_addr  <= '0;
      r_sccb_data  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wait_first <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_rom_addr   <= w_rom_addr_next;
      r_sccb_start <= w_sccb_start_next;
      r_sccb_addr  <= w_sccb_addr_next;
      r_sccb_data  <= w_sccb_data_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_wait_first <= w_wait_first_next;
    end
  end

  assign o_rom_addr   = r_rom_addr;
  assign o_sccb_start = r_sccb_start;
  assign o_sccb_addr  = r_sccb_addr;
  assign o_sccb_data  = r_sccb_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_cam_cfg_ctrl.sv
// Scoreboard bench for cam_cfg_ctrl: behavioural ROM and SCCB master, table-walk reference model.
module tb_cam_cfg_ctrl;

  localparam int N   = 256;
  localparam int DLY = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data = 16'h0;
  logic        sccb_start;
  logic [7:0]  sccb_addr, sccb_data;
  logic        sccb_ready;
  logic        busy, done;

  always #5 clk = ~clk;

  cam_cfg_ctrl #(.CLK_FREQ_HZ(10_000), .DELAY_MS(1), .ROM_AW(8)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_sccb_start(sccb_start), .o_sccb_addr(sccb_addr), .o_sccb_data(sccb_data),
    .i_sccb_ready(sccb_ready), .o_busy(busy), .o_done(done)
  );

  // ROM with one-cycle registered read
  logic [15:0] rom [N];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // SCCB master: goes busy for busy_len cycles after accepting a start
  int m_cnt = 0;
  int busy_len = 5;
  bit hold_low = 1'b0;
  always @(posedge clk) begin
    if (sccb_start) m_cnt <= busy_len;
    else if (m_cnt > 0) m_cnt <= m_cnt - 1;
  end
  assign sccb_ready = (m_cnt == 0) && !hold_low;

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_starts = 0;
  int addr_cyc [N];
  logic prev_start = 1'b0;
  logic [7:0] prev_addr = 8'h0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    wr_t e;
    if (rom_addr != prev_addr) addr_cyc[rom_addr] = cyc;
    prev_addr = rom_addr;
    if (sccb_start) begin
      n_starts++;
      checks++;
      if (prev_start || !sccb_ready) begin
        errors++;
        $display("FAIL start_protocol: start with prev_start=%0b ready=%0b, required prev_start=0 ready=1",
                 prev_start, sccb_ready);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%02h data=%02h, required no write", sccb_addr, sccb_data);
      end else begin
        e = exp_q.pop_front();
        if (sccb_addr !== e.a || sccb_data !== e.d) begin
          errors++;
          $display("FAIL write_value: got %02h/%02h, required %02h/%02h", sccb_addr, sccb_data, e.a, e.d);
        end else begin
          $display("write #%0d addr=%02h data=%02h", n_starts, sccb_addr, sccb_data);
        end
      end
    end
    prev_start = sccb_start;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: writes are the non-marker entries up to the first end marker; the
  // sequencer stops at the marker's address, or at the last address when none exists.
  task automatic build_expected(output int final_addr, output int nwr);
    bit ended;
    ended = 1'b0;
    nwr = 0;
    final_addr = N - 1;
    for (int a = 0; a < N; a++) begin
      if (!ended) begin
        if (rom[a] == 16'hFFFF) begin
          final_addr = a;
          ended = 1'b1;
        end else if (rom[a] != 16'hFFF0) begin
          exp_q.push_back('{rom[a][15:8], rom[a][7:0]});
          nwr++;
        end
      end
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done_timeout"}, {31'd0, done}, 32'd1);
  endtask

  task automatic run_table(input string name);
    int fa, nw, n0;
    build_expected(fa, nw);
    n0 = n_starts;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({name, "_busy_after_start"}, {30'd0, busy, done}, 32'd2);
    wait_done(name);
    chk({name, "_pending_writes"}, exp_q.size(), 32'd0);
    chk({name, "_write_count"}, n_starts - n0, nw);
    chk({name, "_final_addr"}, {24'd0, rom_addr}, fa);
    chk({name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    $display("table %s: %0d writes, final addr %0d", name, nw, fa);
    exp_q.delete();
  endtask

  function automatic logic [15:0] rand_entry();
    logic [15:0] v;
    if ($urandom_range(0, 5) == 0) return 16'hFFF0;
    v = 16'($urandom);
    while (v == 16'hFFFF || v == 16'hFFF0) v = 16'($urandom);
    return v;
  endfunction

  task automatic reset_pulse(input string name);
    rstn = 1'b0;
    @(negedge clk);
    chk({name, "_outputs"}, {6'd0, rom_addr, sccb_start, sccb_addr, sccb_data, busy, done}, 32'd0);
    rstn = 1'b1;
    exp_q.delete();
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int k, fa, nw, n0, len;
    for (int a = 0; a < N; a++) rom[a] = 16'hFFFF;

    // Reset state and idle without start
    repeat (3) @(negedge clk);
    chk("reset_outputs", {6'd0, rom_addr, sccb_start, sccb_addr, sccb_data, busy, done}, 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_start", {30'd0, busy, done}, 32'd0);

    // Writes, delay entry, entry overhead
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1101; rom[3] = 16'hFFFF;
    busy_len = 5;
    build_expected(fa, nw);
    n0 = n_starts;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 1;
    while (!sccb_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("first_start_latency", k, 32'd4);
    wait_done("t1");
    chk("t1_pending_writes", exp_q.size(), 32'd0);
    chk("t1_start_count", n_starts - n0, 32'd2);
    chk("t1_final_addr", {24'd0, rom_addr}, 32'd3);
    chk("t2_delay_cycles", addr_cyc[2] - addr_cyc[1] - 2, DLY);
    repeat (10) @(negedge clk);
    chk("t1_done_held", {23'd0, done, rom_addr}, {23'd0, 1'b1, 8'd3});
    $display("table t1: writes 12/80 11/01 with delay");

    // Ready withheld in WR_REQ
    rom[0] = 16'h5A3C; rom[1] = 16'h7711; rom[2] = 16'hFFFF;
    hold_low = 1'b1;
    build_expected(fa, nw);
    n0 = n_starts;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    k = 0;
    for (int i = 0; i < 50; i++) begin
      if (sccb_start || sccb_addr != 8'h5A || sccb_data != 8'h3C) k++;
      @(negedge clk);
    end
    chk("t3_held_stable", k, 32'd0);
    chk("t3_no_start_while_not_ready", n_starts - n0, 32'd0);
    hold_low = 1'b0;
    wait_done("t3");
    chk("t3_pending_writes", exp_q.size(), 32'd0);
    chk("t3_start_count", n_starts - n0, 32'd2);
    $display("table t3: ready withheld 50 cycles");

    // No terminator: every address written, stop at last address
    for (int a = 0; a < N; a++) rom[a] = 16'h3A04;
    busy_len = 2;
    run_table("t4");
    repeat (20) @(negedge clk);
    chk("t4_no_wrap", {23'd0, done, rom_addr}, {23'd0, 1'b1, 8'd255});

    // Reset while a write is in flight
    for (int a = 0; a < N; a++) rom[a] = 16'hFFFF;
    rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'hFFFF;
    busy_len = 4;
    build_expected(fa, nw);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 0;
    while (!sccb_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t5_wr_start_seen", {31'd0, sccb_start}, 32'd1);
    reset_pulse("t5_reset_wr_wait");

    // Reset during a delay entry, then restart from address 0
    rom[0] = 16'hFFF0; rom[1] = 16'h3333; rom[2] = 16'hFFFF;
    repeat (10) @(negedge clk);
    n0 = n_starts;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_in_delay_busy", {30'd0, busy, done}, 32'd2);
    reset_pulse("t5_reset_delay");
    repeat (15) @(negedge clk);
    chk("t5_stays_idle", {29'd0, busy, done, 1'b0} | (n_starts - n0), 32'd0);
    run_table("t5_restart");

    // Start held high while busy, then replay from DONE
    for (int a = 0; a < 8; a++) rom[a] = {8'(a + 8'h20), 8'($urandom)};
    rom[8] = 16'hFFFF;
    busy_len = 3;
    build_expected(fa, nw);
    n0 = n_starts;
    @(negedge clk) start = 1'b1;
    repeat (30) @(negedge clk);
    start = 1'b0;
    wait_done("t6");
    chk("t6_pending_writes", exp_q.size(), 32'd0);
    chk("t6_start_count", n_starts - n0, 32'd8);
    build_expected(fa, nw);
    n0 = n_starts;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("t6_done_clears", {30'd0, busy, done}, 32'd2);
    wait_done("t6_replay");
    chk("t6_replay_pending", exp_q.size(), 32'd0);
    chk("t6_replay_count", n_starts - n0, 32'd8);
    chk("t6_replay_addr", {24'd0, rom_addr}, 32'd8);
    $display("table t6: held start ignored, replay identical");

    // Randomised tables
    for (int t = 0; t < 6; t++) begin
      busy_len = $urandom_range(1, 8);
      len = $urandom_range(1, 24);
      for (int a = 0; a < N; a++) rom[a] = rand_entry();
      rom[len] = 16'hFFFF;
      run_table($sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
